// File: rtl/icache_data_ram_arbiter_if.sv
// Bundle between the icache controller, the data RAM and icache_data_ram_arbiter.
// Optional perf counter signals exist only when ICACHE_DATA_ARB_PERF_EN is defined.
interface icache_data_ram_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  flush_req_i;
    logic                  flush_busy_o;
    logic                  dbg_state;

    // Handshakes: a fetch read happens in the cycle fetch_req_i & fetch_gnt_o,
    // a refill write in the cycle refill_valid_i & refill_ready_o; grants are
    // combinational and a requester may hold or change its request at any time.
    logic                  fetch_req_i;
    logic [ADDR_WIDTH-1:0] fetch_addr_i;
    logic                  fetch_gnt_o;
    logic                  fetch_rvalid_o;
    logic [DATA_WIDTH-1:0] fetch_rdata_o;

    logic                  refill_valid_i;
    logic [ADDR_WIDTH-1:0] refill_addr_i;
    logic [DATA_WIDTH-1:0] refill_data_i;
    logic [BE_WIDTH-1:0]   refill_be_i;
    logic                  refill_ready_o;

    logic                  ram_req_o;
    logic                  ram_write_o;
    logic [ADDR_WIDTH-1:0] ram_raddr_o;
    logic [ADDR_WIDTH-1:0] ram_waddr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [BE_WIDTH-1:0]   ram_be_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

`ifdef ICACHE_DATA_ARB_PERF_EN
    logic                  perf_clear_i;
    logic [31:0]           perf_fetch_stall_o;
    logic [31:0]           perf_refill_stall_o;
`endif

    modport master (
        output flush_req_i, fetch_req_i, fetch_addr_i,
        output refill_valid_i, refill_addr_i, refill_data_i, refill_be_i,
        output ram_rdata_i,
`ifdef ICACHE_DATA_ARB_PERF_EN
        output perf_clear_i,
        input  perf_fetch_stall_o, perf_refill_stall_o,
`endif
        input  flush_busy_o, dbg_state, fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        input  refill_ready_o,
        input  ram_req_o, ram_write_o, ram_raddr_o, ram_waddr_o, ram_wdata_o, ram_be_o
    );

    modport slave (
        input  flush_req_i, fetch_req_i, fetch_addr_i,
        input  refill_valid_i, refill_addr_i, refill_data_i, refill_be_i,
        input  ram_rdata_i,
`ifdef ICACHE_DATA_ARB_PERF_EN
        input  perf_clear_i,
        output perf_fetch_stall_o, perf_refill_stall_o,
`endif
        output flush_busy_o, dbg_state, fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        output refill_ready_o,
        output ram_req_o, ram_write_o, ram_raddr_o, ram_waddr_o, ram_wdata_o, ram_be_o
    );
endinterface

// File: rtl/icache_data_ram_arbiter.sv
// Shares the icache data RAM between fetch reads and refill writes and sweeps it clear
// after reset/flush. Define ICACHE_DATA_ARB_PERF_EN to add the stall perf counters.
module icache_data_ram_arbiter #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 7,
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_WR_STREAK = 4
) (
    input logic                 clk,
    input logic                 rst,
    icache_data_ram_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_WR_STREAK + 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [SW-1:0]         wr_streak_q, wr_streak_d;
    logic                  rvalid_q;

    logic                  starve;
    logic                  fetch_gnt;
    logic                  refill_ready;
    logic                  refill_acc;
    logic                  ram_req;
    logic                  ram_write;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [BE_WIDTH-1:0]   ram_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            wr_streak_q <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            wr_streak_q <= wr_streak_d;
            rvalid_q    <= fetch_gnt;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        fetch_gnt    = 1'b0;
        refill_ready = 1'b0;
        ram_req      = 1'b0;
        ram_write    = 1'b0;
        ram_raddr    = '0;
        ram_waddr    = '0;
        ram_wdata    = '0;
        ram_be       = '0;
        starve       = (wr_streak_q >= SW'(MAX_WR_STREAK));

        case (state_q)
            CLEAR: begin
                ram_req   = 1'b1;
                ram_write = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_be    = '1;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (&clr_cnt_q) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end
            end
            RUN: begin
                // Refill wins by default; a waiting fetch gets through once starved.
                refill_ready = ~(bus.fetch_req_i & starve);
                fetch_gnt    = bus.fetch_req_i & (~bus.refill_valid_i | starve);
                if (fetch_gnt) begin
                    ram_req   = 1'b1;
                    ram_raddr = bus.fetch_addr_i;
                end else if (bus.refill_valid_i & refill_ready) begin
                    ram_req   = 1'b1;
                    ram_write = 1'b1;
                    ram_waddr = bus.refill_addr_i;
                    ram_wdata = bus.refill_data_i;
                    ram_be    = bus.refill_be_i;
                end
                if (bus.flush_req_i) state_d = CLEAR;
            end
            default: state_d = CLEAR;
        endcase

        refill_acc = bus.refill_valid_i & refill_ready;

        if (fetch_gnt || !bus.fetch_req_i) wr_streak_d = '0;
        else if (refill_acc && !starve)    wr_streak_d = wr_streak_q + SW'(1);
        else                               wr_streak_d = wr_streak_q;
    end

    assign bus.flush_busy_o   = (state_q == CLEAR);
    assign bus.dbg_state      = state_q;
    assign bus.fetch_gnt_o    = fetch_gnt;
    assign bus.refill_ready_o = refill_ready;
    assign bus.fetch_rvalid_o = rvalid_q;
    assign bus.fetch_rdata_o  = rvalid_q ? bus.ram_rdata_i : '0;
    assign bus.ram_req_o      = ram_req;
    assign bus.ram_write_o    = ram_write;
    assign bus.ram_raddr_o    = ram_raddr;
    assign bus.ram_waddr_o    = ram_waddr;
    assign bus.ram_wdata_o    = ram_wdata;
    assign bus.ram_be_o       = ram_be;

`ifdef ICACHE_DATA_ARB_PERF_EN
    logic [31:0] perf_fetch_q, perf_refill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q  <= '0;
            perf_refill_q <= '0;
        end else if (bus.perf_clear_i) begin
            perf_fetch_q  <= '0;
            perf_refill_q <= '0;
        end else begin
            if (bus.fetch_req_i && !fetch_gnt && (perf_fetch_q != '1))
                perf_fetch_q <= perf_fetch_q + 32'd1;
            if (bus.refill_valid_i && !refill_ready && (perf_refill_q != '1))
                perf_refill_q <= perf_refill_q + 32'd1;
        end
    end

    assign bus.perf_fetch_stall_o  = perf_fetch_q;
    assign bus.perf_refill_stall_o = perf_refill_q;
`endif
endmodule

// File: tb/tb_icache_data_ram_arbiter.sv
// Randomized bench for icache_data_ram_arbiter with a behavioural RAM and reference model.
// Perf counter checks are compiled in when ICACHE_DATA_ARB_PERF_EN is defined.
module tb_icache_data_ram_arbiter;
  localparam int DW   = 64;
  localparam int AW   = 3;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;
  localparam int NW   = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_data_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW)) bus();

  icache_data_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW), .MAX_WR_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- data RAM (environment) ----------------
  logic          junk_fill;
  logic [DW-1:0] ram_arr [NW];

  always @(posedge clk) begin
    if (junk_fill) begin
      for (int i = 0; i < NW; i++) ram_arr[i] <= {$urandom, $urandom};
    end else if (bus.ram_req_o && bus.ram_write_o) begin
      for (int b = 0; b < BW; b++)
        if (bus.ram_be_o[b]) ram_arr[bus.ram_waddr_o][b*8 +: 8] <= bus.ram_wdata_o[b*8 +: 8];
    end
    // Read data is garbage whenever no read was issued.
    if (bus.ram_req_o && !bus.ram_write_o) bus.ram_rdata_i <= ram_arr[bus.ram_raddr_o];
    else                                   bus.ram_rdata_i <= {$urandom, $urandom};
  end

  // ---------------- reference model ----------------
  bit            m_clear;
  int            m_clr_idx;
  int            m_streak;       // refills won in a row while a fetch waited
  logic [DW-1:0] mem_ref [NW];
  logic [DW-1:0] exp_q [$];      // read data owed to the fetch port next cycle
`ifdef ICACHE_DATA_ARB_PERF_EN
  logic [31:0]   m_perf_f, m_perf_r;
  logic [31:0]   obs_perf_f;
  bit            in_perf_clear;
`endif

  bit            in_f_req, in_r_val, in_flush;
  logic [AW-1:0] in_f_addr, in_r_addr;
  logic [DW-1:0] in_r_data;
  logic [BW-1:0] in_r_be;
  bit            e_fg, e_rr, e_acc;
  logic          obs_busy, obs_fg, obs_rr, obs_rvalid;
  logic [DW-1:0] obs_rdata;

  // ---------------- driver tasks ----------------
  task automatic drive();
    bus.fetch_req_i    = in_f_req;
    bus.fetch_addr_i   = in_f_addr;
    bus.refill_valid_i = in_r_val;
    bus.refill_addr_i  = in_r_addr;
    bus.refill_data_i  = in_r_data;
    bus.refill_be_i    = in_r_be;
    bus.flush_req_i    = in_flush;
`ifdef ICACHE_DATA_ARB_PERF_EN
    bus.perf_clear_i   = in_perf_clear;
`endif
  endtask

  task automatic check_outputs();
    if (m_clear) begin
      e_fg = 1'b0;
      e_rr = 1'b0;
    end else begin
      e_rr = !(in_f_req && m_streak >= MAXS);
      e_fg = in_f_req && (!in_r_val || m_streak >= MAXS);
    end
    e_acc = in_r_val && e_rr;

    obs_busy   = bus.flush_busy_o;
    obs_fg     = bus.fetch_gnt_o;
    obs_rr     = bus.refill_ready_o;
    obs_rvalid = bus.fetch_rvalid_o;
    obs_rdata  = bus.fetch_rdata_o;

    check("flush_busy", bus.flush_busy_o, m_clear);
    check("dbg_state", bus.dbg_state, !m_clear);
    check("fetch_gnt", bus.fetch_gnt_o, e_fg);
    check("refill_ready", bus.refill_ready_o, e_rr);
    check("fetch_rvalid", bus.fetch_rvalid_o, exp_q.size() != 0);
    check("fetch_rdata", bus.fetch_rdata_o, (exp_q.size() != 0) ? exp_q[0] : 64'd0);
    if (m_clear) begin
      check("clr_req", bus.ram_req_o, 1);
      check("clr_write", bus.ram_write_o, 1);
      check("clr_waddr", bus.ram_waddr_o, 64'(m_clr_idx));
      check("clr_wdata", bus.ram_wdata_o, 0);
      check("clr_be", bus.ram_be_o, {BW{1'b1}});
    end else if (e_fg) begin
      check("rd_req", bus.ram_req_o, 1);
      check("rd_write", bus.ram_write_o, 0);
      check("rd_raddr", bus.ram_raddr_o, in_f_addr);
    end else if (e_acc) begin
      check("wr_req", bus.ram_req_o, 1);
      check("wr_write", bus.ram_write_o, 1);
      check("wr_waddr", bus.ram_waddr_o, in_r_addr);
      check("wr_wdata", bus.ram_wdata_o, in_r_data);
      check("wr_be", bus.ram_be_o, in_r_be);
    end else begin
      check("idle_req", bus.ram_req_o, 0);
      check("idle_write", bus.ram_write_o, 0);
      check("idle_raddr", bus.ram_raddr_o, 0);
      check("idle_waddr", bus.ram_waddr_o, 0);
      check("idle_wdata", bus.ram_wdata_o, 0);
      check("idle_be", bus.ram_be_o, 0);
    end
`ifdef ICACHE_DATA_ARB_PERF_EN
    obs_perf_f = bus.perf_fetch_stall_o;
    check("perf_fetch", bus.perf_fetch_stall_o, m_perf_f);
    check("perf_refill", bus.perf_refill_stall_o, m_perf_r);
`endif
  endtask

  task automatic model_update();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (e_fg) exp_q.push_back(mem_ref[in_f_addr]);
    if (e_acc)
      for (int b = 0; b < BW; b++)
        if (in_r_be[b]) mem_ref[in_r_addr][b*8 +: 8] = in_r_data[b*8 +: 8];
`ifdef ICACHE_DATA_ARB_PERF_EN
    if (in_perf_clear) begin
      m_perf_f = 0;
      m_perf_r = 0;
    end else begin
      if (in_f_req && !e_fg && m_perf_f != 32'hFFFF_FFFF) m_perf_f++;
      if (in_r_val && !e_rr && m_perf_r != 32'hFFFF_FFFF) m_perf_r++;
    end
`endif
    if (!in_f_req || e_fg)            m_streak = 0;
    else if (e_acc && m_streak < MAXS) m_streak++;
    if (m_clear) begin
      mem_ref[m_clr_idx] = '0;
      m_clr_idx++;
      if (m_clr_idx == NW) begin
        m_clear   = 1'b0;
        m_clr_idx = 0;
      end
    end else if (in_flush) begin
      m_clear = 1'b1;
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cycle(input bit f_req, input int f_addr, input bit r_val, input int r_addr,
                       input logic [DW-1:0] r_data, input logic [BW-1:0] r_be, input bit flush);
    in_f_req  = f_req;
    in_f_addr = f_addr[AW-1:0];
    in_r_val  = r_val;
    in_r_addr = r_addr[AW-1:0];
    in_r_data = r_data;
    in_r_be   = r_be;
    in_flush  = flush;
    drive();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_f_req  = 1'b1;
    in_r_val  = 1'b1;
    in_f_addr = AW'($urandom);
    in_r_addr = AW'($urandom);
    in_r_data = {$urandom, $urandom};
    in_r_be   = BW'($urandom);
    in_flush  = 1'($urandom);
    drive();
    #1;
    m_clear   = 1'b1;
    m_clr_idx = 0;
    m_streak  = 0;
    exp_q.delete();
`ifdef ICACHE_DATA_ARB_PERF_EN
    m_perf_f  = 0;
    m_perf_r  = 0;
`endif
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    for (int i = 0; i < 4 * NW; i++) begin
      idle();
      if (!obs_busy) break;
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
`ifdef ICACHE_DATA_ARB_PERF_EN
    in_perf_clear = 1'b0;
`endif
    rst       = 1'b1;
    junk_fill = 1'b1;
    in_f_req  = 0; in_r_val = 0; in_flush = 0;
    in_f_addr = '0; in_r_addr = '0; in_r_data = '0; in_r_be = '0;
    drive();
    @(posedge clk);
    #1 junk_fill = 1'b0;
    @(negedge clk);

    // Reset values and the post-reset sweep
    do_reset();
    wait_sweep(n);
    check("sweep_len_after_reset", n, NW);

    // Refill then fetch the same word
    cycle(0, 0, 1, 5, 64'h1122334455667788, 8'hFF, 0);
    cycle(1, 5, 0, 0, '0, '0, 0);
    check("t2_gnt", obs_fg, 1);
    idle();
    check("t2_rvalid", obs_rvalid, 1);
    check("t2_rdata", obs_rdata, 64'h1122334455667788);

    // Fetch granted alongside a flush still returns the old data
    cycle(1, 5, 0, 0, '0, '0, 1);
    check("t5_gnt", obs_fg, 1);
    idle();
    check("t5_rvalid", obs_rvalid, 1);
    check("t5_rdata", obs_rdata, 64'h1122334455667788);
    check("t5_busy", obs_busy, 1);
    wait_sweep(n);
    check("t5_sweep_len", n + 1, NW);
    cycle(1, 5, 0, 0, '0, '0, 0);
    idle();
    check("t5_cleared_rvalid", obs_rvalid, 1);
    check("t5_cleared_rdata", obs_rdata, 0);

    // Continuous contention: four refills, then one fetch
    idle();
    for (int i = 0; i < 15; i++) begin
      cycle(1, i % NW, 1, (i + 3) % NW, {$urandom, $urandom}, 8'hFF, 0);
      check("t3_fetch_gnt", obs_fg, (i % 5) == 4);
      check("t3_refill_ready", obs_rr, (i % 5) != 4);
    end

    // Partial byte-enable write
    idle();
    cycle(0, 0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    cycle(0, 0, 1, 2, 64'h0123_4567_89AB_CDEF, 8'h0F, 0);
    cycle(1, 2, 0, 0, '0, '0, 0);
    idle();
    check("t4_rdata", obs_rdata, 64'hFFFF_FFFF_89AB_CDEF);

    // Reset in the middle of a sweep restarts it from address 0
    cycle(1, 1, 0, 0, '0, '0, 1);
    idle();
    idle();
    idle();
    do_reset();
    wait_sweep(n);
    check("sweep_len_after_mid_reset", n, NW);

    // Randomized traffic with occasional flushes and resets
    for (int it = 0; it < 400; it++) begin
      if (it % 137 == 136) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, NW - 1),
              $urandom_range(0, 9) < 6, $urandom_range(0, NW - 1),
              {$urandom, $urandom}, BW'($urandom), $urandom_range(0, 49) == 0);
      end
    end

`ifdef ICACHE_DATA_ARB_PERF_EN
    wait_sweep(n);
    in_perf_clear = 1'b1;
    idle();
    in_perf_clear = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 1, {$urandom, $urandom}, 8'hFF, 0);
    idle();
    check("perf_fetch_stall_10", obs_perf_f, 8);
    in_perf_clear = 1'b1;
    idle();
    in_perf_clear = 1'b0;
    idle();
    check("perf_fetch_stall_cleared", obs_perf_f, 0);
`endif

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
